// File: rtl/srambank_generic.sv
// Word-addressed SRAM bank with per-lane write mask, 1- or 2-cycle read latency
// and a self-clearing sweep that runs after reset and on an init request.
module srambank_generic #(
    parameter int WORDS  = 1024,
    parameter int WIDTH  = 74,
    parameter int LANES  = 2,
    parameter int RD_LAT = 1,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ADDRESS,
    input  logic [WIDTH-1:0] wd,
    input  logic [LANES-1:0] wmask,
    input  logic             banksel,
    input  logic             read,
    input  logic             write,
    input  logic             init,
    output logic             ready,
    output logic [WIDTH-1:0] dataout,
    output logic             rvalid
);

    localparam int            LW        = WIDTH / LANES;
    localparam logic [AW:0]   WORDS_EXT = (AW + 1)'(WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("srambank_generic: RD_LAT must be 1 or 2");
    end
    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("srambank_generic: WIDTH must be divisible by LANES");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_addr, clr_addr_nxt;
    logic [WIDTH-1:0] mem [WORDS];
    logic             in_range, acc, wr_acc, rd_acc;
    logic [WIDTH-1:0] rd_word;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_data;

    // The compare is one bit wider than ADDRESS so WORDS = 2**AW still fits.
    assign in_range = {1'b0, ADDRESS} < WORDS_EXT;
    assign ready    = (state == RUN);
    assign acc      = ready && banksel;
    assign wr_acc   = acc && write;
    assign rd_acc   = acc && read && !write;
    assign rd_word  = in_range ? mem[ADDRESS] : '0;

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            CLEAR: begin
                clr_addr_nxt = clr_addr + 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt    = RUN;
                    clr_addr_nxt = '0;
                end
            end
            RUN: begin
                if (init) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = CLEAR;
                clr_addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // No reset on the array: the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem[ADDRESS][i*LW +: LW] <= wd[i*LW +: LW];
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic             p_valid;
        logic [WIDTH-1:0] p_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_valid <= 1'b0;
                p_data  <= '0;
            end else begin
                p_valid <= rd_acc;
                if (rd_acc) begin
                    p_data <= rd_word;
                end
            end
        end

        assign fin_valid = p_valid;
        assign fin_data  = p_data;
    end else begin : g_lat1
        assign fin_valid = rd_acc;
        assign fin_data  = rd_word;
    end

    // dataout only moves with rvalid, so it holds the last read between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid  <= 1'b0;
            dataout <= '0;
        end else begin
            rvalid <= fin_valid;
            if (fin_valid) begin
                dataout <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_srambank_generic.sv
// Bench for srambank_generic: two instances (1024 words / RD_LAT 1 and 1000 words /
// RD_LAT 2) share one stimulus stream and are checked against a behavioural model.
module tb_srambank_generic;

    typedef struct packed {
        int          due;
        logic [73:0] data;
    } rd_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [9:0]  addr    = '0;
    logic [73:0] wd      = '0;
    logic [1:0]  wmask   = '0;
    logic        banksel = 1'b0;
    logic        read    = 1'b0;
    logic        write   = 1'b0;
    logic        init    = 1'b0;

    logic        ready_a, ready_b, rvalid_a, rvalid_b;
    logic [73:0] dout_a, dout_b;
    logic        rv [2];
    logic        rdy [2];
    logic [73:0] dq [2];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          words_m [2] = '{1024, 1000};
    int          lat_m [2]   = '{1, 2};
    logic [73:0] mm [2][1024];
    int          clr_left [2];
    logic        exp_rv [2];
    logic [73:0] exp_do [2];
    rd_t         exp_q0[$];
    rd_t         exp_q1[$];

    srambank_generic #(.WORDS(1024), .WIDTH(74), .LANES(2), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ADDRESS(addr), .wd(wd), .wmask(wmask),
        .banksel(banksel), .read(read), .write(write), .init(init),
        .ready(ready_a), .dataout(dout_a), .rvalid(rvalid_a)
    );

    srambank_generic #(.WORDS(1000), .WIDTH(74), .LANES(2), .RD_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ADDRESS(addr), .wd(wd), .wmask(wmask),
        .banksel(banksel), .read(read), .write(write), .init(init),
        .ready(ready_b), .dataout(dout_b), .rvalid(rvalid_b)
    );

    assign rv[0]  = rvalid_a;
    assign rv[1]  = rvalid_b;
    assign rdy[0] = ready_a;
    assign rdy[1] = ready_b;
    assign dq[0]  = dout_a;
    assign dq[1]  = dout_b;

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset(input int d);
        clr_left[d] = words_m[d];
        exp_rv[d]   = 1'b0;
        exp_do[d]   = '0;
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
        for (int a = 0; a < 1024; a++) mm[d][a] = '0;
    endtask

    // Applies the effect of the coming rising edge to the model.
    task automatic model_edge();
        rd_t e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                model_reset(d);
            end else begin
                exp_rv[d] = 1'b0;
                if (clr_left[d] > 0) begin
                    clr_left[d]--;
                end else begin
                    if (banksel && write) begin
                        if (int'(addr) < words_m[d]) begin
                            if (wmask[0]) mm[d][addr][36:0]  = wd[36:0];
                            if (wmask[1]) mm[d][addr][73:37] = wd[73:37];
                        end
                    end else if (banksel && read) begin
                        e.due  = cyc + lat_m[d] - 1;
                        e.data = (int'(addr) < words_m[d]) ? mm[d][addr] : 74'd0;
                        if (d == 0) exp_q0.push_back(e);
                        else        exp_q1.push_back(e);
                    end
                    if (init) begin
                        clr_left[d] = words_m[d];
                        for (int a = 0; a < 1024; a++) mm[d][a] = '0;
                    end
                end
                if (d == 0 && exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
                    e = exp_q0.pop_front();
                    exp_rv[0] = 1'b1;
                    exp_do[0] = e.data;
                end
                if (d == 1 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
                    e = exp_q1.pop_front();
                    exp_rv[1] = 1'b1;
                    exp_do[1] = e.data;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic bs, input logic rd, input logic wr, input logic in,
                         input logic [1:0] wm, input logic [9:0] a, input logic [73:0] d);
        banksel = bs;
        read    = rd;
        write   = wr;
        init    = in;
        wmask   = wm;
        addr    = a;
        wd      = d;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [73:0] rand_word();
        return 74'({$urandom(), $urandom(), $urandom()});
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        model_reset(0);
        model_reset(1);
        #1;
        total += 4;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin bad++; $display("FAIL reset.ready got=%b%b want=00", ready_a, ready_b); end
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL reset.rvalid got=%b%b want=00", rvalid_a, rvalid_b); end
        if (dout_a !== 74'd0) begin bad++; $display("FAIL reset.dout_a got=%h want=0", dout_a); end
        if (dout_b !== 74'd0) begin bad++; $display("FAIL reset.dout_b got=%h want=0", dout_b); end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                total += 3;
                if (rdy[d] !== (clr_left[d] == 0)) begin bad++; $display("FAIL sweep.ready[%0d] got=%b want=%b", d, rdy[d], clr_left[d] == 0); end
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL sweep.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL sweep.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
            if (i == 1022) begin total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL sweep.a_early got=%b want=0", ready_a); end end
            if (i == 1023) begin total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL sweep.a_rise got=%b want=1", ready_a); end end
            if (i == 998)  begin total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL sweep.b_early got=%b want=0", ready_b); end end
            if (i == 999)  begin total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL sweep.b_rise got=%b want=1", ready_b); end end
        end
        for (int i = 0; i < 30; i++) begin
            drive(1, i < 27, 0, 0, 2'b11, 10'($urandom_range(0, 1023)), rand_word());
            tick();
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL zero_read.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== 74'd0) begin bad++; $display("FAIL zero_read.dataout[%0d] got=%h want=0", d, dq[d]); end
            end
        end
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
    endtask

    task automatic test_lane_mask();
        logic [73:0] want;
        want = {{37{1'b1}}, 37'd0};
        drive(1, 0, 1, 0, 2'b11, 10'd5, {74{1'b1}});
        tick();
        drive(1, 0, 1, 0, 2'b01, 10'd5, 74'd0);
        tick();
        drive(1, 1, 0, 0, 2'b00, 10'd5, 74'd0);
        tick();
        total += 2;
        if (rvalid_a !== 1'b1) begin bad++; $display("FAIL lane.rvalid_a got=%b want=1", rvalid_a); end
        if (dout_a !== want) begin bad++; $display("FAIL lane.dout_a got=%h want=%h", dout_a, want); end
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                total += 2;
                if (rvalid_b !== 1'b1) begin bad++; $display("FAIL lane.rvalid_b got=%b want=1", rvalid_b); end
                if (dout_b !== want) begin bad++; $display("FAIL lane.dout_b got=%h want=%h", dout_b, want); end
            end
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL lane.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL lane.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [73:0] dat [3];
        for (int k = 0; k < 3; k++) begin
            dat[k] = rand_word();
            drive(1, 0, 1, 0, 2'b11, 10'(k + 1), dat[k]);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1, 1, 0, 0, 2'b00, 10'(k + 1), 74'd0);
            else       drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
            tick();
            if (k < 3) begin
                total += 2;
                if (rvalid_a !== 1'b1) begin bad++; $display("FAIL b2b.rvalid_a got=%b want=1", rvalid_a); end
                if (dout_a !== dat[k]) begin bad++; $display("FAIL b2b.dout_a got=%h want=%h", dout_a, dat[k]); end
            end
            if (k >= 1 && k <= 3) begin
                total += 2;
                if (rvalid_b !== 1'b1) begin bad++; $display("FAIL b2b.rvalid_b got=%b want=1", rvalid_b); end
                if (dout_b !== dat[k-1]) begin bad++; $display("FAIL b2b.dout_b got=%h want=%h", dout_b, dat[k-1]); end
            end
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL b2b.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL b2b.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
        end
    endtask

    task automatic test_collision();
        drive(1, 1, 1, 0, 2'b11, 10'd7, 74'h3);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 3) begin
                total++;
                if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL rw.no_rvalid got=%b%b want=00", rvalid_a, rvalid_b); end
            end
            if (k == 4) begin
                total++;
                if (dout_a !== 74'h3) begin bad++; $display("FAIL rw.dout_a got=%h want=3", dout_a); end
            end
            if (k == 5) begin
                total++;
                if (dout_b !== 74'h3) begin bad++; $display("FAIL rw.dout_b got=%h want=3", dout_b); end
            end
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL rw.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL rw.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
            if (k == 3) drive(1, 1, 0, 0, 2'b00, 10'd7, 74'd0);
            else        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        end
    endtask

    task automatic test_out_of_range();
        logic [9:0] a_tab [6] = '{10'd1010, 10'd999, 10'd1023, 10'd1010, 10'd1000, 10'd999};
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 2'b11, a_tab[k], rand_word());
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            if (k < 6) drive(1, 1, 0, 0, 2'b00, a_tab[k], 74'd0);
            else       drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
            tick();
            if (k == 1) begin
                total += 2;
                if (rvalid_b !== 1'b1) begin bad++; $display("FAIL oor.rvalid_b got=%b want=1", rvalid_b); end
                if (dout_b !== 74'd0) begin bad++; $display("FAIL oor.dout_b got=%h want=0", dout_b); end
            end
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL oor.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL oor.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 1'b0,
                  2'($urandom_range(0, 3)), 10'($urandom_range(0, 31) + (($urandom_range(0, 7) == 0) ? 992 : 0)),
                  rand_word());
            tick();
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL rand.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL rand.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
        end
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        repeat (3) tick();
    endtask

    task automatic test_init();
        logic [73:0] old;
        old = rand_word();
        drive(1, 0, 1, 0, 2'b11, 10'd10, old);
        tick();
        drive(1, 1, 0, 1, 2'b00, 10'd10, 74'd0);
        tick();
        total += 3;
        if (rvalid_a !== 1'b1 || dout_a !== old) begin bad++; $display("FAIL init.a_old got=%b/%h want=1/%h", rvalid_a, dout_a, old); end
        if (ready_a !== 1'b0) begin bad++; $display("FAIL init.ready_a got=%b want=0", ready_a); end
        if (ready_b !== 1'b0) begin bad++; $display("FAIL init.ready_b got=%b want=0", ready_b); end
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        tick();
        total++;
        if (rvalid_b !== 1'b1 || dout_b !== old) begin bad++; $display("FAIL init.b_inflight got=%b/%h want=1/%h", rvalid_b, dout_b, old); end
        for (int i = 0; i < 1030; i++) begin
            drive(1, $urandom_range(0, 1) == 1, 0, 1'($urandom_range(0, 1)), 2'b00, 10'($urandom_range(0, 20)), 74'd0);
            if (i > 1020) drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
            tick();
            for (int d = 0; d < 2; d++) begin
                total += 3;
                if (rdy[d] !== (clr_left[d] == 0)) begin bad++; $display("FAIL init.ready[%0d] got=%b want=%b", d, rdy[d], clr_left[d] == 0); end
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL init.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL init.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1, 1, 0, 0, 2'b00, (k == 0) ? 10'd10 : 10'($urandom_range(0, 1023)), 74'd0);
            else       drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
            tick();
            for (int d = 0; d < 2; d++) begin
                total += 2;
                if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL init.clr_rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                if (dq[d] !== 74'd0) begin bad++; $display("FAIL init.cleared[%0d] got=%h want=0", d, dq[d]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, 0, 2'b11, 10'd12, rand_word());
        tick();
        drive(1, 1, 0, 0, 2'b00, 10'd12, 74'd0);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        model_reset(0);
        model_reset(1);
        #1;
        total += 2;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL rstmid.rvalid got=%b%b want=00", rvalid_a, rvalid_b); end
        if (dout_a !== 74'd0 || dout_b !== 74'd0) begin bad++; $display("FAIL rstmid.dataout got=%h/%h want=0", dout_a, dout_b); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < ((pass == 0) ? 500 : 1030); i++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    total += 3;
                    if (rdy[d] !== (clr_left[d] == 0)) begin bad++; $display("FAIL rstmid.ready[%0d] got=%b want=%b", d, rdy[d], clr_left[d] == 0); end
                    if (rv[d] !== exp_rv[d]) begin bad++; $display("FAIL rstmid.rvalid[%0d] got=%b want=%b", d, rv[d], exp_rv[d]); end
                    if (dq[d] !== exp_do[d]) begin bad++; $display("FAIL rstmid.dataout[%0d] got=%h want=%h", d, dq[d], exp_do[d]); end
                end
            end
            if (pass == 0) begin
                rst_n = 1'b0;
                model_reset(0);
                model_reset(1);
                tick();
                rst_n = 1'b1;
            end
        end
        drive(1, 1, 0, 0, 2'b00, 10'd12, 74'd0);
        tick();
        drive(0, 0, 0, 0, 2'b00, 10'd0, 74'd0);
        tick();
        total += 2;
        if (rvalid_b !== 1'b1) begin bad++; $display("FAIL rstmid.final_rvalid_b got=%b want=1", rvalid_b); end
        if (dout_a !== 74'd0 || dout_b !== 74'd0) begin bad++; $display("FAIL rstmid.final_zero got=%h/%h want=0", dout_a, dout_b); end
    endtask

    initial begin
        test_reset();
        test_lane_mask();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_random();
        test_init();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
